mem_lsu: RTL and testbench

MEM_LSU -- requirements
Module: mem_lsu

---
 rtl/mem_lsu_pkg.sv | 22 ++
 rtl/mem_lsu_if.sv | 11 +
 rtl/mem_lsu_load_extend.sv | 14 +
 rtl/mem_lsu.sv | 117 +++++++++++
 tb/tb_mem_lsu.sv | 171 +++++++++++++++++
 5 files changed

// File: rtl/mem_lsu_pkg.sv
// mem_lsu_pkg: access codes, FSM states and byte-count helpers for the load/store unit
package mem_lsu_pkg;
    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;
    localparam logic [4:0] ACC_NONE = 5'd0;
    localparam logic [4:0] ACC_LB   = 5'd1;
    localparam logic [4:0] ACC_LH   = 5'd2;
    localparam logic [4:0] ACC_LW   = 5'd3;
    localparam logic [4:0] ACC_LBU  = 5'd4;
    localparam logic [4:0] ACC_LHU  = 5'd5;
    localparam logic [4:0] ACC_SB   = 5'd6;
    localparam logic [4:0] ACC_SH   = 5'd7;
    localparam logic [4:0] ACC_SW   = 5'd8;
    // bytes moved by an access; 0 marks "no access" (including unknown codes)
    function automatic logic [2:0] byte_count(input logic [4:0] code);
        return (code == ACC_LB || code == ACC_LBU || code == ACC_SB) ? 3'd1 :
               (code == ACC_LH || code == ACC_LHU || code == ACC_SH) ? 3'd2 :
               (code == ACC_LW || code == ACC_SW) ? 3'd4 : 3'd0;
    endfunction
    function automatic logic is_store(input logic [4:0] code);
        return code == ACC_SB || code == ACC_SH || code == ACC_SW;
    endfunction
endpackage

// File: rtl/mem_lsu_if.sv
// mem_lsu_if: byte-serial memory controller bus between the LSU and the controller
interface mem_lsu_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [7:0]  wdata;
    logic [7:0]  rdata;
    logic        ack;
    modport master (output req, we, addr, wdata, input rdata, ack);
    modport slave  (input req, we, addr, wdata, output rdata, ack);
endinterface

// File: rtl/mem_lsu_load_extend.sv
// load_extend: sign/zero extension of the assembled load word by access code
import mem_lsu_pkg::*;
module load_extend (
    input  logic [4:0]  code,
    input  logic [31:0] raw,
    output logic [31:0] res
);
    // byte/half loads extend from their low lane, words pass through
    always_comb
        res = code == ACC_LB  ? {{24{raw[7]}}, raw[7:0]} :
              code == ACC_LH  ? {{16{raw[15]}}, raw[15:0]} :
              code == ACC_LBU ? {24'd0, raw[7:0]} :
              code == ACC_LHU ? {16'd0, raw[15:0]} : raw;
endmodule

// File: rtl/mem_lsu.sv
// mem_lsu: byte-serial load/store unit; optional alignment trap under MEM_ALIGN_CHECK_EN
import mem_lsu_pkg::*;
module mem_lsu (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     rd_data_i,
    input  logic [4:0]      rd_addr_i,
    input  logic            rd_e_i,
    input  logic [31:0]     mem_addr_i,
    input  logic [4:0]      mem_length_i,
    mem_lsu_if.master       mctl,
    output logic [31:0]     rd_data_o,
    output logic [4:0]      rd_addr_o,
    output logic            rd_e_o,
    output logic            stall_req,
    output logic            misalign_o
);
    state_t      state, state_n;
    logic [1:0]  idx;
    logic [31:0] base, wdat, raw, ext;
    logic [4:0]  rd_addr_q, code_q;
    logic        rd_e_q, st_q, mis_q, mis_in, last;
    logic [2:0]  n_q, n_in;
    logic [31:0] addr_in;

    assign n_in    = byte_count(mem_length_i);
    assign addr_in = is_store(mem_length_i) ? mem_addr_i : rd_data_i;
    assign last    = {1'b0, idx} == n_q - 3'd1;
`ifdef MEM_ALIGN_CHECK_EN
    assign mis_in  = (n_in == 3'd2 && addr_in[0]) || (n_in == 3'd4 && addr_in[1:0] != 2'd0);
`else
    assign mis_in  = 1'b0;
`endif

    load_extend u_ext (.code(code_q), .raw(raw), .res(ext));

    // state register plus request latches and byte-lane capture
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            idx       <= '0;
            base      <= '0;
            wdat      <= '0;
            raw       <= '0;
            rd_addr_q <= '0;
            rd_e_q    <= 1'b0;
            code_q    <= '0;
            n_q       <= '0;
            st_q      <= 1'b0;
            mis_q     <= 1'b0;
        end else begin
            state <= state_n;
            if (state == IDLE && n_in != 3'd0) begin
                idx       <= '0;
                base      <= addr_in;
                wdat      <= rd_data_i;
                raw       <= '0;
                rd_addr_q <= rd_addr_i;
                rd_e_q    <= rd_e_i;
                code_q    <= mem_length_i;
                n_q       <= n_in;
                st_q      <= is_store(mem_length_i);
                mis_q     <= mis_in;
            end else if (state == ACCESS && mctl.ack) begin
                if (!st_q) raw[{idx, 3'b000} +: 8] <= mctl.rdata;
                idx <= idx + 2'd1;
            end
        end
    end

    // next state and outputs; reset forces every output low combinationally
    always_comb begin
        state_n    = state;
        rd_data_o  = rd_data_i;
        rd_addr_o  = rd_addr_i;
        rd_e_o     = rd_e_i;
        stall_req  = 1'b0;
        misalign_o = 1'b0;
        mctl.req   = 1'b0;
        mctl.we    = 1'b0;
        mctl.addr  = '0;
        mctl.wdata = '0;
        case (state)
            IDLE: if (n_in != 3'd0) begin
                stall_req = 1'b1;
                state_n   = mis_in ? DONE : ACCESS;
            end
            ACCESS: begin
                stall_req  = 1'b1;
                mctl.req   = 1'b1;
                mctl.we    = st_q;
                mctl.addr  = base + {30'd0, idx};
                mctl.wdata = wdat[{idx, 3'b000} +: 8];
                if (mctl.ack && last) state_n = DONE;
            end
            DONE: begin
                rd_addr_o  = rd_addr_q;
                rd_e_o     = (st_q || mis_q) ? 1'b0 : rd_e_q;
                rd_data_o  = (st_q || mis_q) ? 32'd0 : ext;
                misalign_o = mis_q;
                state_n    = IDLE;
            end
            default: state_n = IDLE;
        endcase
        if (!rst) begin
            rd_data_o  = '0;
            rd_addr_o  = '0;
            rd_e_o     = 1'b0;
            stall_req  = 1'b0;
            misalign_o = 1'b0;
            mctl.req   = 1'b0;
            mctl.we    = 1'b0;
            mctl.addr  = '0;
            mctl.wdata = '0;
        end
    end
endmodule

// File: tb/tb_mem_lsu.sv
// tb_mem_lsu: directed checks of mem_lsu against a byte-memory responder with programmable ack delay
module tb_mem_lsu;
    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] rd_data_i, mem_addr_i, rd_data_o;
    logic [4:0]  rd_addr_i, mem_length_i, rd_addr_o;
    logic        rd_e_i, rd_e_o, stall_req, misalign_o;
    int          total = 0, bad = 0, delay = 0, wc = 0;
    logic        spur = 1'b0;
    logic [7:0]  mem [0:511];
    logic [31:0] la[$];
    logic [8:0]  lw[$];

    mem_lsu_if mctl ();

    mem_lsu dut (
        .clk(clk), .rst(rst), .rd_data_i(rd_data_i), .rd_addr_i(rd_addr_i), .rd_e_i(rd_e_i),
        .mem_addr_i(mem_addr_i), .mem_length_i(mem_length_i), .mctl(mctl),
        .rd_data_o(rd_data_o), .rd_addr_o(rd_addr_o), .rd_e_o(rd_e_o),
        .stall_req(stall_req), .misalign_o(misalign_o)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h exp=%h", tag, got, exp);
        end
    endtask

    // responder: acks after `delay` wait cycles, logs every acked byte
    initial begin
        mctl.ack = 1'b0;
        mctl.rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mctl.req && !spur) begin
                if (wc == delay) begin
                    mctl.ack = 1'b1;
                    mctl.rdata = mem[mctl.addr[8:0]];
                    la.push_back(mctl.addr);
                    lw.push_back({mctl.we, mctl.wdata});
                    wc = 0;
                end else begin
                    mctl.ack = 1'b0;
                    wc++;
                end
            end else begin
                mctl.ack = spur;
                mctl.rdata = 8'hEE;
                wc = 0;
            end
        end
    end

    task automatic run_access(input string tag, input logic [4:0] code, input logic [31:0] data,
                              input logic [31:0] maddr, input int dly, input int exp_cyc,
                              input logic [31:0] exp_data, input logic exp_e, input logic exp_mis);
        int cyc;
        delay = dly;
        la.delete();
        lw.delete();
        rd_data_i = data;
        rd_addr_i = 5'd9;
        rd_e_i = 1'b1;
        mem_addr_i = maddr;
        mem_length_i = code;
        @(negedge clk);
        check({tag, "_stall_start"}, {31'd0, stall_req}, 1);
        cyc = 0;
        while (cyc < 100) begin
            @(negedge clk);
            cyc++;
            if (!stall_req) break;
        end
        check({tag, "_cycles"}, cyc, exp_cyc);
        check({tag, "_data"}, rd_data_o, exp_data);
        check({tag, "_rd_e"}, {31'd0, rd_e_o}, {31'd0, exp_e});
        check({tag, "_rd_addr"}, {27'd0, rd_addr_o}, 9);
        check({tag, "_mis"}, {31'd0, misalign_o}, {31'd0, exp_mis});
        check({tag, "_done_req"}, {31'd0, mctl.req}, 0);
        @(posedge clk);
        #1;
        check({tag, "_no_restart"}, {31'd0, mctl.req}, 0);
        check({tag, "_mis_pulse"}, {31'd0, misalign_o}, 0);
        mem_length_i = 5'd0;
    endtask

    initial begin
        #200000;
        $display("FAIL timeout: got=running exp=finished");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'h00;
        mem[9'h100] = 8'h78;
        mem[9'h101] = 8'h56;
        mem[9'h102] = 8'h34;
        mem[9'h103] = 8'h12;
        mem[9'h007] = 8'h80;
        rst = 1'b0;
        rd_data_i = 32'h55;
        rd_addr_i = 5'd3;
        rd_e_i = 1'b1;
        mem_addr_i = '0;
        mem_length_i = 5'd0;
        #3;
        check("rst_data", rd_data_o, 0);
        check("rst_rd_e", {31'd0, rd_e_o}, 0);
        check("rst_addr", {27'd0, rd_addr_o}, 0);
        check("rst_stall", {31'd0, stall_req}, 0);
        repeat (2) @(posedge clk);
        #2 rst = 1'b1;
        rd_data_i = 32'h1234;
        rd_addr_i = 5'd5;
        #1;
        check("pass_data", rd_data_o, 32'h1234);
        check("pass_addr", {27'd0, rd_addr_o}, 5);
        check("pass_rd_e", {31'd0, rd_e_o}, 1);
        check("pass_stall", {31'd0, stall_req}, 0);
        check("pass_req", {31'd0, mctl.req}, 0);
        rd_data_i = 32'hBEEF;
        #1;
        check("pass_comb", rd_data_o, 32'hBEEF);
        spur = 1'b1;
        repeat (2) @(negedge clk);
        check("spur_stall", {31'd0, stall_req}, 0);
        check("spur_req", {31'd0, mctl.req}, 0);
        @(posedge clk);
        #2 spur = 1'b0;
        run_access("lw", 5'd3, 32'h100, 32'h0, 0, 5, 32'h12345678, 1'b1, 1'b0);
        check("lw_nbytes", la.size(), 4);
        for (int i = 0; i < 4 && i < la.size(); i++) check("lw_addr", la[i], 32'h100 + i);
        run_access("lb", 5'd1, 32'h7, 32'h0, 0, 2, 32'hFFFFFF80, 1'b1, 1'b0);
        run_access("lbu", 5'd4, 32'h7, 32'h0, 0, 2, 32'h00000080, 1'b1, 1'b0);
        run_access("sh", 5'd7, 32'hAABBCCDD, 32'h20, 3, 9, 32'h0, 1'b0, 1'b0);
        check("sh_nbytes", lw.size(), 2);
        if (lw.size() == 2) begin
            check("sh_addr0", la[0], 32'h20);
            check("sh_byte0", {23'd0, lw[0]}, 32'h1DD);
            check("sh_addr1", la[1], 32'h21);
            check("sh_byte1", {23'd0, lw[1]}, 32'h1CC);
        end
`ifdef MEM_ALIGN_CHECK_EN
        run_access("sw_mis", 5'd8, 32'h55, 32'h102, 0, 1, 32'h0, 1'b0, 1'b1);
        check("sw_mis_nreq", la.size(), 0);
`endif
        delay = 0;
        rd_data_i = 32'h100;
        mem_length_i = 5'd3;
        repeat (4) @(negedge clk);
        check("mid_req_before", {31'd0, mctl.req}, 1);
        rst = 1'b0;
        #1;
        check("mid_req", {31'd0, mctl.req}, 0);
        check("mid_stall", {31'd0, stall_req}, 0);
        check("mid_rd_e", {31'd0, rd_e_o}, 0);
        check("mid_data", rd_data_o, 0);
        @(posedge clk);
        #2 rst = 1'b1;
        run_access("lw2", 5'd3, 32'h100, 32'h0, 0, 5, 32'h12345678, 1'b1, 1'b0);
        check("lw2_nbytes", la.size(), 4);
        if (la.size() > 0) check("lw2_first", la[0], 32'h100);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
